dcache_miss_ctrl: RTL and testbench

Memory-stage controller for the data cache. Sits between the X/M pipeline register and the M/WB pipeline register. Serves LW/SW hits in the same cycle. On a miss it stalls the pipeline, fills the whole block from main memory, writes the tag, and then completes the access. It drives the write enable of the M/WB register.

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_fill_cnt.sv | 40 ++++
 rtl/dcache_miss_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss controller.
package dcache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int WORDS_PER_BLK = 8;  // 16-bit words per block
  localparam int OFFSET_W      = 4;  // byte offset bits within a block
  localparam int IDX_W         = 3;  // word index bits within a block

endpackage

// File: rtl/dcache_fill_cnt.sv
// Small up-counter with synchronous clear, count enable and saturation.
// Used for the fill request counter and the fill receive counter.
module dcache_fill_cnt #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up until the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Memory-stage data-cache controller: same-cycle LW/SW hits, write-through
// stores, and a stalling whole-block fill on a miss. A miss completes by
// re-evaluating the held access as a hit once the tag has been written.
//
// Memory handshake: mem_enable is a one-cycle request (no ready); memory
// answers every read with exactly one mem_data_valid pulse, in order, and
// the controller accepts every returned word (no back-pressure).
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic              hit,
  input  logic [15:0]       cache_rdata,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              tag_we,
  output logic              store_we,
  output logic [15:0]       data_out,
  output logic              stall,
  output logic              wb_wen,
  output logic              dbg_state
);

  localparam int REQ_W = IDX_W + 1;
  localparam logic [REQ_W-1:0] ReqLimit = REQ_W'(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(WORDS_PER_BLK - 1);

  state_e state_q;
  state_e state_d;

  logic [REQ_W-1:0] req_cnt_q;
  logic [IDX_W-1:0] rcv_cnt_q;
  logic             cnt_clr;
  logic             req_en;
  logic             rcv_en;

  // Returned words go straight into the data array; the controller only
  // produces the write strobe and index for them.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all combinational outputs; everything defaults to idle.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    req_en     = 1'b0;
    rcv_en     = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = 1'b0;
    fill_idx   = '0;
    tag_we     = 1'b0;
    store_we   = 1'b0;
    data_out   = '0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (hit) begin
            if (mem_write) begin
              // Write-through: update the array and memory together.
              store_we   = 1'b1;
              mem_enable = 1'b1;
              mem_wr     = 1'b1;
              mem_addr   = addr;
              mem_wdata  = wdata;
            end else begin
              data_out = cache_rdata;
            end
          end else begin
            stall   = 1'b1;
            cnt_clr = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        // Issue one word read per cycle until the whole block is requested.
        if (req_cnt_q < ReqLimit) begin
          mem_enable = 1'b1;
          mem_addr   = {addr[ADDR_W-1:OFFSET_W], req_cnt_q[IDX_W-1:0], 1'b0};
          req_en     = 1'b1;
        end
        // Accept returns as they arrive; the last word also writes the tag.
        if (mem_data_valid) begin
          fill_we  = 1'b1;
          fill_idx = rcv_cnt_q;
          rcv_en   = 1'b1;
          if (rcv_cnt_q == LastIdx) begin
            tag_we  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_wen    = ~stall;
  assign dbg_state = (state_q == FILL);

  dcache_fill_cnt #(
    .W   (REQ_W),
    .MAX (WORDS_PER_BLK)
  ) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (req_en),
    .cnt_o (req_cnt_q)
  );

  dcache_fill_cnt #(
    .W   (IDX_W),
    .MAX (WORDS_PER_BLK - 1)
  ) u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (rcv_en),
    .cnt_o (rcv_cnt_q)
  );

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: the bench plays tag array and main memory,
// and a timeline model predicts every output cycle by cycle.
module tb_dcache_miss_ctrl;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_write, hit, mem_data_valid;
  logic [15:0] addr, wdata, cache_rdata, mem_rdata;
  logic        mem_enable, mem_wr, fill_we, tag_we, store_we, stall, wb_wen, dbg_state;
  logic [15:0] mem_addr, mem_wdata, data_out;
  logic [2:0]  fill_idx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_miss_ctrl #(.ADDR_W(16), .WORDS_PER_BLK(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .hit(hit), .cache_rdata(cache_rdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .fill_we(fill_we), .fill_idx(fill_idx),
    .tag_we(tag_we), .store_we(store_we), .data_out(data_out),
    .stall(stall), .wb_wen(wb_wen), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  bit          valid_blk[int];   // tag array: block number -> valid
  int          resp_q[$];        // memory: cycles in which a read word returns
  bit          in_miss = 1'b0;
  int          t0, m_l, k;
  int          cur_l = 4;
  int          tag_we_seen = 0;
  logic [15:0] exp_q[$];         // expected outputs of the current cycle
  logic [15:0] e_addr, e_wdata, e_dout, e_idx;
  logic        e_stall, e_en, e_wr, e_fwe, e_twe, e_swe, e_dbg;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: a miss detected in cycle t0 with latency L puts requests
  // in t0+1..t0+8, returns in t0+1+L..t0+8+L, tag write in t0+8+L.
  always @(negedge clk) begin
    if (tag_we === 1'b1) tag_we_seen++;
    if (!rst_n) begin
      in_miss = 1'b0;
      resp_q.delete();
    end else begin
      e_stall = 0; e_en = 0; e_wr = 0; e_fwe = 0; e_twe = 0; e_swe = 0; e_dbg = 0;
      e_addr = 0; e_wdata = 0; e_dout = 0; e_idx = 0;
      if (!in_miss && mem_req && !hit) begin
        in_miss = 1'b1; t0 = cyc; m_l = cur_l;
      end
      if (in_miss) begin
        k = cyc - t0;
        e_stall = 1'b1;
        e_dbg   = (k >= 1);
        if (k >= 1 && k <= 8) begin
          e_en   = 1'b1;
          e_addr = {addr[15:4], 4'h0} + 16'(2 * (k - 1));
        end
        if (k >= 1 + m_l && k <= 8 + m_l) begin
          e_fwe = 1'b1;
          e_idx = 16'(k - 1 - m_l);
        end
        if (k == 8 + m_l) begin
          e_twe = 1'b1;
          valid_blk[int'(addr[15:4])] = 1'b1;
          in_miss = 1'b0;
        end
      end else if (mem_req) begin
        if (mem_write) begin
          e_swe = 1'b1; e_en = 1'b1; e_wr = 1'b1; e_addr = addr; e_wdata = wdata;
        end else begin
          e_dout = cache_rdata;
        end
      end
      exp_q.delete();
      exp_q.push_back(16'(e_stall)); exp_q.push_back(16'(!e_stall));
      exp_q.push_back(16'(e_en));    exp_q.push_back(e_addr);
      exp_q.push_back(e_wdata);      exp_q.push_back(16'(e_fwe));
      exp_q.push_back(e_idx);        exp_q.push_back(16'(e_twe));
      exp_q.push_back(16'(e_swe));   exp_q.push_back(e_dout);
      exp_q.push_back(16'(e_dbg));
      chk("stall",      16'(stall),      exp_q[0]);
      chk("wb_wen",     16'(wb_wen),     exp_q[1]);
      chk("mem_enable", 16'(mem_enable), exp_q[2]);
      chk("mem_addr",   mem_addr,        exp_q[3]);
      chk("mem_wdata",  mem_wdata,       exp_q[4]);
      chk("fill_we",    16'(fill_we),    exp_q[5]);
      chk("fill_idx",   16'(fill_idx),   exp_q[6]);
      chk("tag_we",     16'(tag_we),     exp_q[7]);
      chk("store_we",   16'(store_we),   exp_q[8]);
      chk("data_out",   data_out,        exp_q[9]);
      chk("dbg_state",  16'(dbg_state),  exp_q[10]);
      if (e_en) chk("mem_wr", 16'(mem_wr), 16'(e_wr));
      // memory side: schedule a return for each read request
      if (mem_enable === 1'b1 && mem_wr === 1'b0) resp_q.push_back(cyc + cur_l);
      if (resp_q.size() > 0 && resp_q[0] == cyc) void'(resp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: drive after the rising edge, return just after the falling
  // edge once the model has checked the outputs.
  task automatic drive(input logic rn, input logic req, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] crd, input logic stray);
    @(posedge clk); #1;
    rst_n       = rn;
    mem_req     = req;
    mem_write   = wr;
    addr        = a;
    wdata       = wd;
    cache_rdata = crd;
    hit         = valid_blk.exists(int'(a[15:4])) != 0;
    mem_data_valid = stray || (resp_q.size() > 0 && resp_q[0] == cyc);
    mem_rdata   = 16'(cyc) ^ 16'hC3C3;
    @(negedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  // Hold one access until it completes; returns after its completion cycle.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] crd, input int lat);
    int g;
    g = 0;
    cur_l = lat;
    drive(1'b1, 1'b1, wr, a, wd, crd, 1'b0);
    if (in_miss) begin
      while (in_miss && g < 64) begin
        drive(1'b1, 1'b1, wr, a, wd, crd, 1'b0);
        g++;
      end
      if (in_miss) begin
        checks++; errors++;
        $display("FAIL access_timeout addr %h: miss still open, required closed", a);
      end
      drive(1'b1, 1'b1, wr, a, wd, crd, 1'b0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int seen0;
    rst_n = 0; mem_req = 0; mem_write = 0; addr = 0; wdata = 0; hit = 0;
    cache_rdata = 0; mem_data_valid = 0; mem_rdata = 0;
    valid_blk[int'(16'h0024 >> 4)] = 1'b1;
    valid_blk[int'(16'h0010 >> 4)] = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);

    // reset state
    idle_cycle();
    chk("reset_stall", 16'(stall), 16'h0);
    chk("reset_wb_wen", 16'(wb_wen), 16'h1);
    chk("reset_state", 16'(dbg_state), 16'h0);

    // LW hit
    drive(1'b1, 1'b1, 1'b0, 16'h0024, 16'h0, 16'hBEEF, 1'b0);
    chk("lw_hit_data", data_out, 16'hBEEF);
    chk("lw_hit_memen", 16'(mem_enable), 16'h0);

    // SW hit (write-through)
    drive(1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0, 1'b0);
    chk("sw_hit_addr", mem_addr, 16'h0010);
    chk("sw_hit_wdata", mem_wdata, 16'h1234);
    chk("sw_hit_store", 16'(store_we), 16'h1);
    idle_cycle();

    // LW miss at 0x1236 with latency 4, cycle by cycle
    cur_l = 4;
    for (int c = 0; c <= 13; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h1236, 16'h0, 16'h5A5A, 1'b0);
      if (c == 1)  chk("lw_miss_req_first", mem_addr, 16'h1230);
      if (c == 8)  chk("lw_miss_req_last", mem_addr, 16'h123E);
      if (c == 5)  chk("lw_miss_fill_first", 16'(fill_idx), 16'h0);
      if (c == 12) chk("lw_miss_fill_last", 16'(fill_idx), 16'h7);
      if (c == 12) chk("lw_miss_tag_we", 16'(tag_we), 16'h1);
      if (c == 12) chk("lw_miss_stall_hi", 16'(stall), 16'h1);
      if (c == 13) chk("lw_miss_stall_lo", 16'(stall), 16'h0);
      if (c == 13) chk("lw_miss_data", data_out, 16'h5A5A);
    end
    idle_cycle();

    // SW miss with write-allocate, latency 2
    access(1'b1, 16'h2002, 16'h00AA, 16'h0, 2);
    chk("sw_miss_store", 16'(store_we), 16'h1);
    chk("sw_miss_addr", mem_addr, 16'h2002);
    chk("sw_miss_wdata", mem_wdata, 16'h00AA);
    idle_cycle();

    // latency 1: returns overlap requests in the same cycle
    access(1'b0, 16'h4008, 16'h0, 16'h7777, 1);
    chk("l1_miss_data", data_out, 16'h7777);
    idle_cycle();

    // stray returns while idle must be ignored
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      chk("stray_fill_we", 16'(fill_we), 16'h0);
    end
    // a following miss must start its fill at index 0
    access(1'b0, 16'h500C, 16'h0, 16'h1111, 3);
    idle_cycle();

    // reset in cycle 6 of a fill
    cur_l = 3;
    seen0 = tag_we_seen;
    for (int c = 0; c <= 5; c++) drive(1'b1, 1'b1, 1'b0, 16'h3004, 16'h0, 16'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h3004, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h3004, 16'h0, 16'h0, 1'b0);
    chk("rst_fill_stall", 16'(stall), 16'h0);
    chk("rst_fill_state", 16'(dbg_state), 16'h0);
    chk("rst_fill_no_tag", 16'(tag_we_seen - seen0), 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h3004, 16'h0, 16'h0, 1'b0);
    chk("rst_fill_remiss", 16'(stall), 16'h1);
    while (in_miss) drive(1'b1, 1'b1, 1'b0, 16'h3004, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h3004, 16'h0, 16'h9999, 1'b0);
    chk("rst_fill_complete", data_out, 16'h9999);
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not reach its end, required completion");
    $fatal(1);
  end

endmodule
